// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// MULTICYCLE_ADDI_EN adds the ADDIEX/ADDIWB states and makes opcode 001000 legal.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
`ifdef MULTICYCLE_ADDI_EN
    ,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       busy;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ) || (op == OP_J);
`ifdef MULTICYCLE_ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_decode.sv
// Combinational map from controller state (and memory handshake) to datapath controls.
// MULTICYCLE_ADDI_EN adds the addi execute/writeback rows.
module multicycle_decode
  import multicycle_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o      = '0;
    ctrl_o.busy = (state_i != S_IDLE);
    case (state_i)
      S_FETCH: begin
        // IR and PC+4 are captured only on the cycle the memory delivers.
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.iord      = 1'b0;
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = 1'b0;
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
        ctrl_o.mem_to_reg = 1'b0;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencing controller: state register, next-state logic and retire counter.
// MULTICYCLE_ADDI_EN enables addi execution; otherwise opcode 001000 decodes as illegal.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  state_t           boundary;
  ctrl_t            ctrl;

  // The branch decision is made in the datapath from pc_write_cond and zero.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // run is only consulted here and in IDLE, so an instruction always completes.
  assign boundary = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = boundary;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = boundary;
        end
      end
      S_EXEC:   state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: begin
        retire  = 1'b1;
        state_d = boundary;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin
        retire  = 1'b1;
        state_d = boundary;
      end
`endif
      default:  state_d = S_IDLE;
    endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end

  multicycle_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    pc_write      = ctrl.pc_write;
    pc_write_cond = ctrl.pc_write_cond;
    iord          = ctrl.iord;
    mem_read      = ctrl.mem_read;
    mem_write     = ctrl.mem_write;
    ir_write      = ctrl.ir_write;
    mem_to_reg    = ctrl.mem_to_reg;
    reg_dst       = ctrl.reg_dst;
    reg_write     = ctrl.reg_write;
    alu_src_a     = ctrl.alu_src_a;
    alu_src_b     = ctrl.alu_src_b;
    alu_op        = ctrl.alu_op;
    pc_src        = ctrl.pc_src;
    busy          = ctrl.busy;
    illegal       = (state_q == S_DECODE) && !op_supported(opcode);
    instr_count   = cnt_q;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the MIPS datapath. It replaces the single-cycle control unit when the processor is rebuilt around a shared instruction/data memory. The datapath gains an instruction register, A/B/ALUOut registers, and a memory with a ready handshake. The block is a Moore-style FSM plus a few handshake-qualified strobes, and it drives every datapath mux select and write enable.

## Interface
Parameters:
- CNT_W, default 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- run  in  1  start/continue execution; sampled only in IDLE and at instruction boundaries.
- opcode  in  6  IR[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero (beq).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load the instruction register.
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  write register select: 0 = rt, 1 = rd.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  0 = PC, 1 = A register.
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct field; same encoding as the existing ALU_control.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- busy  out  1  high in every state except IDLE.
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
- instr_count  out  CNT_W  count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB.
- Outputs not listed for a state are 0.
- IDLE: all outputs are 0. Move to FETCH when run = 1.
- FETCH:
  - Static outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write are asserted only while mem_ready = 1. These are the only two mem_ready-qualified outputs in this state.
  - Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXEC.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - 001000 (addi) → ADDIEX.
  - Any other opcode → pulse illegal, retire nothing, go to the boundary check.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready = 1, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Retire.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready = 1, then retire.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. Retire regardless of zero.
- JUMP: pc_write=1, pc_src=10. Retire.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Retire.
- Retire:
  - instr_count increments by 1; it wraps modulo 2^CNT_W with no saturation.
  - Boundary check: next state is FETCH if run = 1, IDLE if run = 0.
  - Dropping run in the middle of an instruction never aborts that instruction.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

## Timing
- Latency with mem_ready held at 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each extra cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- Illegal opcode: 2 cycles, FETCH then DECODE.
- The state register and instr_count are registered.
- Outputs are decoded combinationally from the current state. The exceptions are ir_write and pc_write in FETCH, which are combinationally qualified by mem_ready.
- Reset: the state goes to IDLE and instr_count to 0 on the clock edge where reset = 1. All outputs are 0 in the following cycle.
- Reset has priority over every transition, including the middle of a memory wait.

## Configuration
- MULTICYCLE_ADDI_EN defined: the ADDIEX/ADDIWB states exist and opcode 001000 executes as addi.
- MULTICYCLE_ADDI_EN undefined: those states are not compiled, and opcode 001000 is illegal (illegal pulse, no register write, not counted).

## Structure
- Shared package multicycle_pkg holds:
  - the state enum;
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - the alu_op, alu_src_b and pc_src encodings.
- Sub-module multicycle_decode: a purely combinational map from (state, mem_ready) to control outputs.
- The top module holds the next-state logic, the state register and the counter.

## Test plan
- Reset with run=1, mem_ready=1: all outputs are 0 and the FSM is in IDLE for one cycle, then FETCH. instr_count = 0.
- lw (opcode 100011) with mem_ready stuck at 0 for 3 cycles in MEMRD: reg_write=1 exactly 8 cycles after leaving IDLE, and instr_count = 1.
- beq with zero=1, then with zero=0: pc_write_cond=1 and pc_src=01 in the 3rd cycle in both cases, and instr_count increments by 2.
- Opcode 111111: illegal pulses in the DECODE cycle, the FSM returns to FETCH, instr_count is unchanged, and no write enable is asserted.
- run dropped in EXEC of an R-type: ALUWB still asserts reg_write=1, then the FSM enters IDLE and busy=0.
- instr_count preset near wrap (CNT_W=4; 15 retirements then one more): the count reads 0. Build without MULTICYCLE_ADDI_EN: addi flags illegal.
